// File: rtl/s_msg_buffer.sv
// s_msg_buffer: frames SPI slave byte traffic on chip select, stores received bytes in an RX
// buffer read by the display, and streams a host-written TX buffer back to the SPI engine.
// All SPI-domain status inputs are double-flopped, edge-detected and registered as events.
// Optional build macro: S_MSG_BUFFER_LOOPBACK_EN echoes every stored RX byte into the TX buffer.
module s_msg_buffer #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       DEPTH  = 64,
  parameter int unsigned       ADDR_W = 6,
  parameter int unsigned       WRAP   = 0,
  parameter logic [DATA_W-1:0] FILL   = 8'h20
) (
  input  logic              clk,
  input  logic              rst_btn,
  input  logic              spi_ss,
  input  logic              spi_rx_busy,
  input  logic              spi_tx_busy,
  input  logic [DATA_W-1:0] spi_rx_data,
  output logic [DATA_W-1:0] spi_tx_data,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   rx_count,
  output logic              rx_overflow,
  output logic              frame_done
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [DATA_W-1:0] tx_mem [DEPTH];

  // Synchroniser and edge-detect stages
  logic ss_meta_q, ss_sync_q, ss_prev_q;
  logic rxb_meta_q, rxb_sync_q, rxb_prev_q;
  logic txb_meta_q, txb_sync_q, txb_prev_q;

  // Framing state and registered events
  logic [1:0] settle_q, settle_d;
  logic       armed_q, armed_d;
  logic       in_frame_q, in_frame_d;
  logic       start_q, end_q, rx_evt_q, tx_evt_q;
  logic       ss_fall, ss_rise, rx_fall, tx_fall;

  // Datapath state
  logic [ADDR_W-1:0] rx_idx_q, rx_idx_d;
  logic [ADDR_W:0]   rx_count_q, rx_count_d;
  logic              rx_ovf_q, rx_ovf_d;
  logic [ADDR_W-1:0] tx_idx_q, tx_idx_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              frame_done_q, frame_done_d;
  logic              rx_we;

  // Edge detection and framing: a frame may only start once ss has genuinely been seen high
  // after reset, so a reset released mid-frame cannot fake a falling edge.
  always_comb begin
    ss_fall    = armed_q & ss_prev_q & ~ss_sync_q;
    ss_rise    = in_frame_q & ~ss_prev_q & ss_sync_q;
    rx_fall    = in_frame_q & ~ss_sync_q & rxb_prev_q & ~rxb_sync_q;
    tx_fall    = in_frame_q & ~ss_sync_q & txb_prev_q & ~txb_sync_q;
    settle_d   = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    armed_d    = armed_q | ((settle_q == 2'd3) & ss_sync_q & ss_prev_q);
    in_frame_d = in_frame_q;
    if (ss_fall) begin
      in_frame_d = 1'b1;
    end else if (ss_rise) begin
      in_frame_d = 1'b0;
    end
  end

  // Event actions; frame start overrides any byte event landing in the same cycle
  always_comb begin
    rx_idx_d     = rx_idx_q;
    rx_count_d   = rx_count_q;
    rx_ovf_d     = rx_ovf_q;
    tx_idx_d     = tx_idx_q;
    tx_data_d    = tx_data_q;
    rx_we        = 1'b0;
    frame_done_d = end_q;
    rd_data_d    = ({1'b0, rd_addr} < rx_count_q) ? rx_mem[rd_addr] : FILL;
    if (start_q) begin
      rx_idx_d   = '0;
      rx_count_d = '0;
      rx_ovf_d   = 1'b0;
      tx_data_d  = tx_mem[0];
      tx_idx_d   = ADDR_W'(1);
    end else begin
      if (rx_evt_q) begin
        if (rx_count_q < DepthCnt) begin
          rx_we      = 1'b1;
          rx_idx_d   = rx_idx_q + ADDR_W'(1);
          rx_count_d = rx_count_q + (ADDR_W + 1)'(1);
        end else begin
          rx_ovf_d = 1'b1;
          if (WRAP != 0) begin
            rx_we    = 1'b1;
            rx_idx_d = rx_idx_q + ADDR_W'(1);
          end
        end
      end
      if (tx_evt_q) begin
        tx_data_d = tx_mem[tx_idx_q];
        tx_idx_d  = tx_idx_q + ADDR_W'(1);
      end
    end
  end

  // Control and status registers; sync flops reset to the idle bus state
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      ss_meta_q    <= 1'b1;
      ss_sync_q    <= 1'b1;
      ss_prev_q    <= 1'b1;
      rxb_meta_q   <= 1'b0;
      rxb_sync_q   <= 1'b0;
      rxb_prev_q   <= 1'b0;
      txb_meta_q   <= 1'b0;
      txb_sync_q   <= 1'b0;
      txb_prev_q   <= 1'b0;
      settle_q     <= 2'd0;
      armed_q      <= 1'b0;
      in_frame_q   <= 1'b0;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      rx_evt_q     <= 1'b0;
      tx_evt_q     <= 1'b0;
      rx_idx_q     <= '0;
      rx_count_q   <= '0;
      rx_ovf_q     <= 1'b0;
      tx_idx_q     <= '0;
      tx_data_q    <= '0;
      rd_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ss_meta_q    <= spi_ss;
      ss_sync_q    <= ss_meta_q;
      ss_prev_q    <= ss_sync_q;
      rxb_meta_q   <= spi_rx_busy;
      rxb_sync_q   <= rxb_meta_q;
      rxb_prev_q   <= rxb_sync_q;
      txb_meta_q   <= spi_tx_busy;
      txb_sync_q   <= txb_meta_q;
      txb_prev_q   <= txb_sync_q;
      settle_q     <= settle_d;
      armed_q      <= armed_d;
      in_frame_q   <= in_frame_d;
      start_q      <= ss_fall;
      end_q        <= ss_rise;
      rx_evt_q     <= rx_fall;
      tx_evt_q     <= tx_fall;
      rx_idx_q     <= rx_idx_d;
      rx_count_q   <= rx_count_d;
      rx_ovf_q     <= rx_ovf_d;
      tx_idx_q     <= tx_idx_d;
      tx_data_q    <= tx_data_d;
      rd_data_q    <= rd_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Buffer storage, never reset; host port has priority over the loopback echo
  always_ff @(posedge clk) begin
    if (rx_we) begin
      rx_mem[rx_idx_q] <= spi_rx_data;
    end
    if (host_we) begin
      tx_mem[host_waddr] <= host_wdata;
    end
`ifdef S_MSG_BUFFER_LOOPBACK_EN
    else if (rx_we) begin
      tx_mem[rx_idx_q] <= spi_rx_data;
    end
`endif
  end

  assign spi_tx_data = tx_data_q;
  assign rd_data     = rd_data_q;
  assign rx_count    = rx_count_q;
  assign rx_overflow = rx_ovf_q;
  assign frame_done  = frame_done_q;

endmodule
